// File: rtl/univ_shift_reg_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usr_pkg
// Description : Shared types for the universal shift register. It defines the
//               mode encoding used on {s1,s0} and a helper that tells whether a
//               mode is one of the two shift modes (the only modes that can
//               start a burst).
// Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DN   = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  // Bursts are only meaningful for the two shifting modes.
  function automatic logic is_shift_mode(input mode_t m);
    return (m == MODE_UP) || (m == MODE_DN);
  endfunction

endpackage : usr_pkg
`default_nettype wire

// File: rtl/univ_shift_reg_n_if.sv
`default_nettype none
// ============================================================================
// Module      : usr_if
// Description : Control/status bundle of the universal shift register.
//               master : the bus side (drives controls, observes status)
//               slave  : the shift register itself
// Signals     : oe1/oe2 (active-low output enables), s0/s1 (mode select),
//               ds0/dsn (serial inputs), rot, start, amount (burst length),
//               q, q0_ser, qn_ser, busy, done.
//               The tri-state bus bidir stays a plain port of the register.
// Revision    : 1.0 - initial release
// ============================================================================
interface usr_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             oe1;
  logic             oe2;
  logic             s0;
  logic             s1;
  logic             ds0;
  logic             dsn;
  logic             rot;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic             q0_ser;
  logic             qn_ser;
  logic             busy;
  logic             done;

  modport master (
    output oe1, oe2, s0, s1, ds0, dsn, rot, start, amount,
    input  q, q0_ser, qn_ser, busy, done
  );

  modport slave (
    input  oe1, oe2, s0, s1, ds0, dsn, rot, start, amount,
    output q, q0_ser, qn_ser, busy, done
  );

endinterface : usr_if
`default_nettype wire

// File: rtl/univ_shift_reg_n_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : usr_burst_ctrl
// Description : Burst sequencer of the universal shift register. Latches the
//               shift mode and rotate flag when a burst starts, counts the
//               remaining shifts and raises a one-cycle done strobe when the
//               last shift has been applied. Produces the effective mode and
//               rotate flag that the datapath should use on this edge.
// Ports       : clk, mr (sync active-low reset)
//               i_mode, i_rot, i_start, i_amount : live controls
//               o_eff_mode, o_eff_rot            : controls for the datapath
//               o_busy, o_done                   : registered status
// Revision    : 1.0 - initial release
// ============================================================================
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  wire logic             clk,
  input  wire logic             mr,
  input  wire mode_t            i_mode,
  input  wire logic             i_rot,
  input  wire logic             i_start,
  input  wire logic [CNT_W-1:0] i_amount,
  output mode_t                 o_eff_mode,
  output logic                  o_eff_rot,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] w_rem_nxt;
  mode_t            r_mode;
  mode_t            w_mode_nxt;
  logic             r_rot;
  logic             w_rot_nxt;
  logic             r_done;
  logic             w_done_nxt;

  logic             w_start_ok;
  logic             w_last;

  // A start is honoured only from idle and only for a shift mode.
  assign w_start_ok = (r_state == S_IDLE) && i_start && is_shift_mode(i_mode);
  assign w_last     = (r_rem == c_CNT_ONE);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!mr) begin
      r_state <= S_IDLE;
      r_rem   <= c_CNT_ZERO;
      r_mode  <= MODE_HOLD;
      r_rot   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_mode  <= w_mode_nxt;
      r_rot   <= w_rot_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_mode_nxt  = r_mode;
    w_rot_nxt   = r_rot;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_mode_nxt = i_mode;
          w_rot_nxt  = i_rot;
          // The start edge already performs the first shift, so only
          // amounts above one need the burst state.
          if (i_amount > c_CNT_ONE) begin
            w_state_nxt = S_BURST;
            w_rem_nxt   = i_amount - c_CNT_ONE;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_BURST: begin
        w_rem_nxt = r_rem - c_CNT_ONE;
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    o_eff_mode = i_mode;
    o_eff_rot  = i_rot;
    if (r_state == S_BURST) begin
      o_eff_mode = r_mode;
      o_eff_rot  = r_rot;
    end else if (w_start_ok && (i_amount == c_CNT_ZERO)) begin
      // A zero-length burst only produces the done strobe.
      o_eff_mode = MODE_HOLD;
    end
  end

  assign o_busy = (r_state == S_BURST);
  assign o_done = r_done;

endmodule : usr_burst_ctrl
`default_nettype wire

// File: rtl/univ_shift_reg_n.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_reg_n
// Description : WIDTH-bit universal shift register with hold, shift-up,
//               shift-down and parallel load from a tri-state bidirectional
//               bus, optional rotate, cascade serial outputs and a multi-step
//               burst shift with busy/done handshake.
// Ports       : clk    - rising-edge clock
//               mr     - master reset, synchronous, active-low
//               bidir  - parallel load input / tri-state output of q
//               bus    - usr_if slave: controls and status (see usr_if)
// Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_reg_n
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  wire logic             clk,
  input  wire logic             mr,
  inout  wire logic [WIDTH-1:0] bidir,
  usr_if.slave                  bus
);

  mode_t            w_mode;
  mode_t            w_eff_mode;
  logic             w_eff_rot;
  logic             w_busy;
  logic             w_done;
  logic             w_in0;
  logic             w_inn;
  logic             w_drive;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;

  assign w_mode = mode_t'({bus.s1, bus.s0});

  usr_burst_ctrl #(
    .CNT_W (CNT_W)
  ) u_burst_ctrl (
    .clk        (clk),
    .mr         (mr),
    .i_mode     (w_mode),
    .i_rot      (bus.rot),
    .i_start    (bus.start),
    .i_amount   (bus.amount),
    .o_eff_mode (w_eff_mode),
    .o_eff_rot  (w_eff_rot),
    .o_busy     (w_busy),
    .o_done     (w_done)
  );

  // Serial fill bits; in rotate mode the bit falling off the far end wraps.
  assign w_in0 = w_eff_rot ? r_q[WIDTH-1] : bus.ds0;
  assign w_inn = w_eff_rot ? r_q[0]       : bus.dsn;

  always_comb begin
    w_q_nxt = r_q;
    case (w_eff_mode)
      MODE_HOLD: w_q_nxt = r_q;
      MODE_UP:   w_q_nxt = {r_q[WIDTH-2:0], w_in0};
      MODE_DN:   w_q_nxt = {w_inn, r_q[WIDTH-1:1]};
      MODE_LOAD: w_q_nxt = bidir;
      default:   w_q_nxt = r_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!mr) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  // The live mode select is used here: while idle with load selected the bus
  // belongs to the external driver, so the register must never fight it.
  assign w_drive = !bus.oe1 && !bus.oe2 && !((w_mode == MODE_LOAD) && !w_busy);
  assign bidir   = w_drive ? r_q : {WIDTH{1'bz}};

  assign bus.q      = r_q;
  assign bus.q0_ser = r_q[0];
  assign bus.qn_ser = r_q[WIDTH-1];
  assign bus.busy   = w_busy;
  assign bus.done   = w_done;

endmodule : univ_shift_reg_n
`default_nettype wire
